// File: rtl/memory_access.sv
// ============================================================================
//  memory_access : pipeline memory stage; issues aligned loads/stores on a
//  request/response data bus and holds the result for writeback.
//  Rev 1.0
// ============================================================================
`default_nettype none

module memory_access (
  input  logic        clk,
  input  logic        reset,

  input  logic        e_valid,
  output logic        e_ready,
  input  logic [63:0] e_pc,
  input  logic [31:0] e_instr,
  input  logic [63:0] e_alu_out,
  input  logic [63:0] e_wdata,
  input  logic        e_memread,
  input  logic        e_memwrite,
  input  logic [1:0]  e_msize,
  input  logic        e_unsigned,
  input  logic [4:0]  e_dst,
  input  logic        e_regwrite,

  output logic        dreq_valid,
  output logic        dreq_write,
  output logic [63:0] dreq_addr,
  output logic [63:0] dreq_wdata,
  output logic [7:0]  dreq_strobe,
  input  logic        dresp_valid,
  input  logic [63:0] dresp_data,

  output logic        m_valid,
  input  logic        m_ready,
  output logic [63:0] m_pc,
  output logic [31:0] m_instr,
  output logic [63:0] m_result,
  output logic [4:0]  m_dst,
  output logic        m_regwrite,
  output logic        m_misalign
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } state_e;

  state_e      state_q, state_d;

  // Fields of the in-flight memory transaction
  logic [63:0] addr_q,     addr_d;
  logic [63:0] wdata_q,    wdata_d;
  logic [7:0]  strobe_q,   strobe_d;
  logic        write_q,    write_d;
  logic [1:0]  msize_q,    msize_d;
  logic        unsigned_q, unsigned_d;
  logic [63:0] pc_q,       pc_d;
  logic [31:0] instr_q,    instr_d;
  logic [4:0]  dst_q,      dst_d;
  logic        regwrite_q, regwrite_d;

  // Output register towards writeback
  logic        m_valid_q,    m_valid_d;
  logic [63:0] m_pc_q,       m_pc_d;
  logic [31:0] m_instr_q,    m_instr_d;
  logic [63:0] m_result_q,   m_result_d;
  logic [4:0]  m_dst_q,      m_dst_d;
  logic        m_regwrite_q, m_regwrite_d;
  logic        m_misalign_q, m_misalign_d;

  logic        w_accept;
  logic        w_is_mem;
  logic [2:0]  w_align_mask;
  logic        w_aligned;
  logic [7:0]  w_strobe_base;
  logic [7:0]  w_strobe;
  logic [63:0] w_wdata_shifted;
  logic [63:0] w_rdata_shifted;
  logic [63:0] w_load_value;

  assign e_ready  = (state_q == S_IDLE) && (!m_valid_q || m_ready);
  assign w_accept = e_valid && e_ready;
  assign w_is_mem = e_memread || e_memwrite;

  always_comb begin
    w_align_mask  = 3'b000;
    w_strobe_base = 8'h01;
    case (e_msize)
      2'd0: begin w_align_mask = 3'b000; w_strobe_base = 8'h01; end
      2'd1: begin w_align_mask = 3'b001; w_strobe_base = 8'h03; end
      2'd2: begin w_align_mask = 3'b011; w_strobe_base = 8'h0F; end
      default: begin w_align_mask = 3'b111; w_strobe_base = 8'hFF; end
    endcase
  end

  assign w_aligned       = ((e_alu_out[2:0] & w_align_mask) == 3'b000);
  assign w_strobe        = w_strobe_base << e_alu_out[2:0];
  assign w_wdata_shifted = e_wdata << {e_alu_out[2:0], 3'b000};

  // Read data arrives as a full dword; move the addressed lane down to bit 0.
  assign w_rdata_shifted = dresp_data >> {addr_q[2:0], 3'b000};

  always_comb begin
    w_load_value = w_rdata_shifted;
    case (msize_q)
      2'd0: w_load_value = unsigned_q ? {56'd0, w_rdata_shifted[7:0]}
                                      : {{56{w_rdata_shifted[7]}}, w_rdata_shifted[7:0]};
      2'd1: w_load_value = unsigned_q ? {48'd0, w_rdata_shifted[15:0]}
                                      : {{48{w_rdata_shifted[15]}}, w_rdata_shifted[15:0]};
      2'd2: w_load_value = unsigned_q ? {32'd0, w_rdata_shifted[31:0]}
                                      : {{32{w_rdata_shifted[31]}}, w_rdata_shifted[31:0]};
      default: w_load_value = w_rdata_shifted;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    strobe_d     = strobe_q;
    write_d      = write_q;
    msize_d      = msize_q;
    unsigned_d   = unsigned_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    dst_d        = dst_q;
    regwrite_d   = regwrite_q;
    m_valid_d    = m_valid_q && !m_ready;
    m_pc_d       = m_pc_q;
    m_instr_d    = m_instr_q;
    m_result_d   = m_result_q;
    m_dst_d      = m_dst_q;
    m_regwrite_d = m_regwrite_q;
    m_misalign_d = m_misalign_q;

    case (state_q)
      S_IDLE: begin
        if (w_accept) begin
          if (!w_is_mem || !w_aligned) begin
            // Non-memory ops and misaligned accesses complete without the bus
            m_valid_d    = 1'b1;
            m_pc_d       = e_pc;
            m_instr_d    = e_instr;
            m_result_d   = e_alu_out;
            m_dst_d      = e_dst;
            m_regwrite_d = w_is_mem ? 1'b0 : e_regwrite;
            m_misalign_d = w_is_mem;
          end else begin
            state_d    = S_REQ;
            addr_d     = e_alu_out;
            wdata_d    = w_wdata_shifted;
            strobe_d   = w_strobe;
            write_d    = e_memwrite;
            msize_d    = e_msize;
            unsigned_d = e_unsigned;
            pc_d       = e_pc;
            instr_d    = e_instr;
            dst_d      = e_dst;
            regwrite_d = e_regwrite;
          end
        end
      end
      S_REQ: begin
        if (dresp_valid) begin
          state_d      = S_IDLE;
          m_valid_d    = 1'b1;
          m_pc_d       = pc_q;
          m_instr_d    = instr_q;
          m_result_d   = write_q ? addr_q : w_load_value;
          m_dst_d      = dst_q;
          m_regwrite_d = regwrite_q;
          m_misalign_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      addr_q       <= 64'd0;
      wdata_q      <= 64'd0;
      strobe_q     <= 8'd0;
      write_q      <= 1'b0;
      msize_q      <= 2'd0;
      unsigned_q   <= 1'b0;
      pc_q         <= 64'd0;
      instr_q      <= 32'd0;
      dst_q        <= 5'd0;
      regwrite_q   <= 1'b0;
      m_valid_q    <= 1'b0;
      m_pc_q       <= 64'd0;
      m_instr_q    <= 32'd0;
      m_result_q   <= 64'd0;
      m_dst_q      <= 5'd0;
      m_regwrite_q <= 1'b0;
      m_misalign_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      strobe_q     <= strobe_d;
      write_q      <= write_d;
      msize_q      <= msize_d;
      unsigned_q   <= unsigned_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      dst_q        <= dst_d;
      regwrite_q   <= regwrite_d;
      m_valid_q    <= m_valid_d;
      m_pc_q       <= m_pc_d;
      m_instr_q    <= m_instr_d;
      m_result_q   <= m_result_d;
      m_dst_q      <= m_dst_d;
      m_regwrite_q <= m_regwrite_d;
      m_misalign_q <= m_misalign_d;
    end
  end

  assign dreq_valid  = (state_q == S_REQ);
  assign dreq_write  = write_q;
  assign dreq_addr   = addr_q;
  assign dreq_wdata  = wdata_q;
  assign dreq_strobe = strobe_q;

  assign m_valid    = m_valid_q;
  assign m_pc       = m_pc_q;
  assign m_instr    = m_instr_q;
  assign m_result   = m_result_q;
  assign m_dst      = m_dst_q;
  assign m_regwrite = m_regwrite_q;
  assign m_misalign = m_misalign_q;

endmodule

`default_nettype wire

// File: tb/tb_memory_access.sv
// ============================================================================
//  tb_memory_access : directed self-checking bench for memory_access.
//  Rev 1.0
// ============================================================================
`default_nettype none

module tb_memory_access;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        e_valid = 1'b0;
  logic        e_ready;
  logic [63:0] e_pc = 64'd0;
  logic [31:0] e_instr = 32'd0;
  logic [63:0] e_alu_out = 64'd0;
  logic [63:0] e_wdata = 64'd0;
  logic        e_memread = 1'b0;
  logic        e_memwrite = 1'b0;
  logic [1:0]  e_msize = 2'd0;
  logic        e_unsigned = 1'b0;
  logic [4:0]  e_dst = 5'd0;
  logic        e_regwrite = 1'b0;
  logic        dreq_valid;
  logic        dreq_write;
  logic [63:0] dreq_addr;
  logic [63:0] dreq_wdata;
  logic [7:0]  dreq_strobe;
  logic        dresp_valid = 1'b0;
  logic [63:0] dresp_data = 64'd0;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic [63:0] m_pc;
  logic [31:0] m_instr;
  logic [63:0] m_result;
  logic [4:0]  m_dst;
  logic        m_regwrite;
  logic        m_misalign;

  int errors = 0;
  int checks = 0;

  memory_access dut (
    .clk(clk), .reset(reset),
    .e_valid(e_valid), .e_ready(e_ready), .e_pc(e_pc), .e_instr(e_instr),
    .e_alu_out(e_alu_out), .e_wdata(e_wdata), .e_memread(e_memread),
    .e_memwrite(e_memwrite), .e_msize(e_msize), .e_unsigned(e_unsigned),
    .e_dst(e_dst), .e_regwrite(e_regwrite),
    .dreq_valid(dreq_valid), .dreq_write(dreq_write), .dreq_addr(dreq_addr),
    .dreq_wdata(dreq_wdata), .dreq_strobe(dreq_strobe),
    .dresp_valid(dresp_valid), .dresp_data(dresp_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_pc(m_pc), .m_instr(m_instr),
    .m_result(m_result), .m_dst(m_dst), .m_regwrite(m_regwrite),
    .m_misalign(m_misalign)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [63:0] addr, input logic [63:0] wdata,
                       input logic rd, input logic wr, input logic [1:0] size,
                       input logic uns, input logic rw);
    e_valid    = 1'b1;
    e_pc       = 64'h1000 + addr;
    e_instr    = 32'h0000_0013;
    e_alu_out  = addr;
    e_wdata    = wdata;
    e_memread  = rd;
    e_memwrite = wr;
    e_msize    = size;
    e_unsigned = uns;
    e_dst      = 5'd7;
    e_regwrite = rw;
  endtask

  // Accept one aligned memory op, check the bus request, answer it, check result.
  task automatic mem_op(input string tag, input logic [63:0] addr, input logic [63:0] wdata,
                        input logic rd, input logic wr, input logic [1:0] size,
                        input logic uns, input logic rw, input logic [7:0] exp_strobe,
                        input logic [63:0] exp_wdata, input logic [63:0] rdata,
                        input logic [63:0] exp_result);
    drive(addr, wdata, rd, wr, size, uns, rw);
    tick();
    e_valid = 1'b0;
    chk({tag, "_dreq_valid"}, {63'd0, dreq_valid}, 64'd1);
    chk({tag, "_dreq_addr"}, dreq_addr, addr);
    chk({tag, "_dreq_write"}, {63'd0, dreq_write}, {63'd0, wr});
    chk({tag, "_dreq_strobe"}, {56'd0, dreq_strobe}, {56'd0, exp_strobe});
    if (wr) chk({tag, "_dreq_wdata"}, dreq_wdata, exp_wdata);
    chk({tag, "_m_valid_wait"}, {63'd0, m_valid}, 64'd0);
    dresp_valid = 1'b1;
    dresp_data  = rdata;
    tick();
    dresp_valid = 1'b0;
    chk({tag, "_m_valid"}, {63'd0, m_valid}, 64'd1);
    chk({tag, "_m_result"}, m_result, exp_result);
    chk({tag, "_m_regwrite"}, {63'd0, m_regwrite}, {63'd0, rw});
    chk({tag, "_dreq_drop"}, {63'd0, dreq_valid}, 64'd0);
  endtask

  initial begin
    // Reset state
    #1;
    chk("rst_m_valid", {63'd0, m_valid}, 64'd0);
    chk("rst_dreq_valid", {63'd0, dreq_valid}, 64'd0);
    chk("rst_m_result", m_result, 64'd0);
    tick();
    tick();
    reset = 1'b1;
    #1;
    chk("rst_e_ready", {63'd0, e_ready}, 64'd1);

    // Plain ALU op: one-cycle latency, no bus traffic
    drive(64'h1234, 64'd0, 1'b0, 1'b0, 2'd3, 1'b0, 1'b1);
    tick();
    e_valid = 1'b0;
    chk("alu_m_valid", {63'd0, m_valid}, 64'd1);
    chk("alu_m_result", m_result, 64'h1234);
    chk("alu_m_dst", {59'd0, m_dst}, 64'd7);
    chk("alu_m_pc", m_pc, 64'h2234);
    chk("alu_no_dreq", {63'd0, dreq_valid}, 64'd0);

    // Loads with lane extraction and extension
    mem_op("lb", 64'h103, 64'd0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 8'h08, 64'd0,
           64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FF80);
    mem_op("lbu", 64'h103, 64'd0, 1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 8'h08, 64'd0,
           64'h0000_0000_8000_0000, 64'h0000_0000_0000_0080);
    mem_op("lh", 64'h002, 64'd0, 1'b1, 1'b0, 2'd1, 1'b0, 1'b1, 8'h0C, 64'd0,
           64'h0000_0000_8001_0000, 64'hFFFF_FFFF_FFFF_8001);
    mem_op("lwu", 64'h004, 64'd0, 1'b1, 1'b0, 2'd2, 1'b1, 1'b1, 8'hF0, 64'd0,
           64'h8765_4321_0000_0000, 64'h0000_0000_8765_4321);
    mem_op("ld_uns", 64'h008, 64'd0, 1'b1, 1'b0, 2'd3, 1'b1, 1'b1, 8'hFF, 64'd0,
           64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001);
    // Read+write together behaves as a store
    mem_op("rw_store", 64'h010, 64'h1122_3344_5566_7788, 1'b1, 1'b1, 2'd3, 1'b0, 1'b0,
           8'hFF, 64'h1122_3344_5566_7788, 64'hDEAD_BEEF_DEAD_BEEF, 64'h010);

    // Store halfword in top lanes; request must hold while the bus stalls
    drive(64'h106, 64'h0000_0000_0000_BEEF, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0);
    tick();
    e_valid = 1'b0;
    chk("sh_strobe", {56'd0, dreq_strobe}, 64'hC0);
    chk("sh_wdata", dreq_wdata, 64'hBEEF_0000_0000_0000);
    chk("sh_write", {63'd0, dreq_write}, 64'd1);
    chk("sh_e_ready_busy", {63'd0, e_ready}, 64'd0);
    tick();
    chk("sh_hold_valid", {63'd0, dreq_valid}, 64'd1);
    chk("sh_hold_strobe", {56'd0, dreq_strobe}, 64'hC0);
    chk("sh_hold_addr", dreq_addr, 64'h106);
    dresp_valid = 1'b1;
    tick();
    dresp_valid = 1'b0;
    chk("sh_m_valid", {63'd0, m_valid}, 64'd1);
    chk("sh_m_result", m_result, 64'h106);
    chk("sh_m_regwrite", {63'd0, m_regwrite}, 64'd0);

    // Misaligned word load: no bus request, flagged result next cycle
    drive(64'h102, 64'd0, 1'b1, 1'b0, 2'd2, 1'b0, 1'b1);
    tick();
    e_valid = 1'b0;
    chk("lw_mis_dreq", {63'd0, dreq_valid}, 64'd0);
    chk("lw_mis_m_valid", {63'd0, m_valid}, 64'd1);
    chk("lw_mis_flag", {63'd0, m_misalign}, 64'd1);
    chk("lw_mis_regwrite", {63'd0, m_regwrite}, 64'd0);
    chk("lw_mis_result", m_result, 64'h102);

    // Backpressure from writeback
    m_ready = 1'b0;
    #1;
    chk("bp_e_ready0", {63'd0, e_ready}, 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_m_valid", {63'd0, m_valid}, 64'd1);
      chk("bp_m_result", m_result, 64'h102);
      chk("bp_m_misalign", {63'd0, m_misalign}, 64'd1);
      chk("bp_e_ready", {63'd0, e_ready}, 64'd0);
    end
    m_ready = 1'b1;
    #1;
    chk("bp_e_ready1", {63'd0, e_ready}, 64'd1);
    tick();
    chk("bp_release", {63'd0, m_valid}, 64'd0);

    // Response while idle is ignored
    dresp_valid = 1'b1;
    tick();
    dresp_valid = 1'b0;
    chk("idle_resp_ignored", {63'd0, m_valid}, 64'd0);

    // Reset in the middle of an outstanding dword load
    drive(64'h200, 64'd0, 1'b1, 1'b0, 2'd3, 1'b0, 1'b1);
    tick();
    e_valid = 1'b0;
    chk("ld_abort_dreq", {63'd0, dreq_valid}, 64'd1);
    chk("ld_abort_strobe", {56'd0, dreq_strobe}, 64'hFF);
    tick();
    reset = 1'b0;
    #1;
    chk("ld_abort_async_drop", {63'd0, dreq_valid}, 64'd0);
    chk("ld_abort_addr_clr", dreq_addr, 64'd0);
    tick();
    reset = 1'b1;
    dresp_valid = 1'b1;
    dresp_data  = 64'h1111_2222_3333_4444;
    tick();
    dresp_valid = 1'b0;
    chk("ld_abort_late_resp", {63'd0, m_valid}, 64'd0);
    tick();
    chk("ld_abort_late_resp2", {63'd0, m_valid}, 64'd0);
    chk("ld_abort_e_ready", {63'd0, e_ready}, 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
